// File: rtl/commit_goal_monitor.sv
// Commit-stream monitor: counts committed micro-ops/ISA ops, tracks last PC,
// and stops on a programmable goal PC or a RUN-cycle timeout.
module commit_goal_monitor #(
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned GOAL_NUM     = 2,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH    = 40,
  localparam int unsigned IDX_W  = (GOAL_NUM > 1) ? $clog2(GOAL_NUM) : 1,
  localparam int unsigned LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                             clk,
  input  logic                             rstOut,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             maxCycles,
  input  logic                             goalWe,
  input  logic [IDX_W-1:0]                 goalIdx,
  input  logic [PC_WIDTH-1:0]              goalPc,
  input  logic                             goalEn,
  input  logic [COMMIT_WIDTH-1:0]          commitValid,
  input  logic [COMMIT_WIDTH-1:0]          commitFirstUop,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commitPc,
  output logic                             running,
  output logic                             done,
  output logic [1:0]                       doneReason,
  output logic [IDX_W-1:0]                 hitGoalIdx,
  output logic [LANE_W-1:0]                hitLane,
  output logic [CNT_WIDTH-1:0]             cycleCount,
  output logic [CNT_WIDTH-1:0]             numMicroOp,
  output logic [CNT_WIDTH-1:0]             numIsaOp,
  output logic [PC_WIDTH-1:0]              lastPc
);

  localparam int unsigned INC_W = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned SUM_W = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT                state;
  logic [PC_WIDTH-1:0]  goalPcTab [GOAL_NUM];
  logic [GOAL_NUM-1:0]  goalEnTab;

  logic                 found;
  logic [LANE_W-1:0]    matchLane;
  logic [IDX_W-1:0]     matchGoal;
  logic [INC_W-1:0]     uopInc;
  logic [INC_W-1:0]     isaInc;
  logic [PC_WIDTH-1:0]  newLastPc;
  logic [CNT_WIDTH-1:0] cycleNext;
  logic                 timeout;

  // Widened add so a multi-lane increment saturates instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [INC_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, a} + SUM_W'(b);
    return sum[CNT_WIDTH] ? CNT_MAX : sum[CNT_WIDTH-1:0];
  endfunction

  // Goal table; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      for (int g = 0; g < GOAL_NUM; g++) goalPcTab[g] <= '0;
      goalEnTab <= '0;
    end else if (goalWe && (32'(goalIdx) < GOAL_NUM)) begin
      goalPcTab[goalIdx] <= goalPc;
      goalEnTab[goalIdx] <= goalEn;
    end
  end

  // First match wins: lowest lane, then lowest goal index.
  always_comb begin
    found     = 1'b0;
    matchLane = '0;
    matchGoal = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      for (int g = 0; g < GOAL_NUM; g++) begin
        if (!found && commitValid[l] && goalEnTab[g] &&
            commitPc[l*PC_WIDTH +: PC_WIDTH] == goalPcTab[g]) begin
          found     = 1'b1;
          matchLane = LANE_W'(l);
          matchGoal = IDX_W'(g);
        end
      end
    end
  end

  // Lanes younger than a matching lane are not counted.
  always_comb begin
    logic stop;
    stop      = 1'b0;
    uopInc    = '0;
    isaInc    = '0;
    newLastPc = lastPc;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      if (commitValid[l] && !stop) begin
        uopInc    = uopInc + INC_W'(1);
        if (commitFirstUop[l]) isaInc = isaInc + INC_W'(1);
        newLastPc = commitPc[l*PC_WIDTH +: PC_WIDTH];
      end
      if (found && (LANE_W'(l) == matchLane)) stop = 1'b1;
    end
  end

  assign cycleNext = satAdd(cycleCount, INC_W'(1));
  assign timeout   = (maxCycles != '0) && (cycleNext == maxCycles);

  // Monitor FSM with registered status and counters.
  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      doneReason <= 2'd0;
      hitGoalIdx <= '0;
      hitLane    <= '0;
      cycleCount <= '0;
      numMicroOp <= '0;
      numIsaOp   <= '0;
      lastPc     <= '0;
    end else if (start) begin
      state      <= RUN;
      running    <= 1'b1;
      done       <= 1'b0;
      doneReason <= 2'd0;
      hitGoalIdx <= '0;
      hitLane    <= '0;
      cycleCount <= '0;
      numMicroOp <= '0;
      numIsaOp   <= '0;
      lastPc     <= '0;
    end else if (state == RUN) begin
      cycleCount <= cycleNext;
      numMicroOp <= satAdd(numMicroOp, uopInc);
      numIsaOp   <= satAdd(numIsaOp, isaInc);
      lastPc     <= newLastPc;
      if (found) begin
        state      <= DONE;
        running    <= 1'b0;
        done       <= 1'b1;
        doneReason <= 2'd1;
        hitGoalIdx <= matchGoal;
        hitLane    <= matchLane;
      end else if (timeout) begin
        state      <= DONE;
        running    <= 1'b0;
        done       <= 1'b1;
        doneReason <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_commit_goal_monitor.sv
// Randomized + directed bench for commit_goal_monitor against a behavioural model.
module tb_commit_goal_monitor;

  localparam int CW   = 4;
  localparam int GN   = 2;
  localparam int PW   = 32;
  localparam int CNTW = 40;
  localparam longint unsigned CMAX = (64'd1 << CNTW) - 1;

  logic            clk, rstOut, start, goalWe, goalEn;
  logic [CNTW-1:0] maxCycles;
  logic [0:0]      goalIdx;
  logic [PW-1:0]   goalPc;
  logic [CW-1:0]   commitValid, commitFirstUop;
  logic [CW*PW-1:0] commitPc;
  logic            running, done;
  logic [1:0]      doneReason;
  logic [0:0]      hitGoalIdx;
  logic [1:0]      hitLane;
  logic [CNTW-1:0] cycleCount, numMicroOp, numIsaOp;
  logic [PW-1:0]   lastPc;

  commit_goal_monitor dut (
    .clk(clk), .rstOut(rstOut), .start(start), .maxCycles(maxCycles),
    .goalWe(goalWe), .goalIdx(goalIdx), .goalPc(goalPc), .goalEn(goalEn),
    .commitValid(commitValid), .commitFirstUop(commitFirstUop), .commitPc(commitPc),
    .running(running), .done(done), .doneReason(doneReason), .hitGoalIdx(hitGoalIdx),
    .hitLane(hitLane), .cycleCount(cycleCount), .numMicroOp(numMicroOp),
    .numIsaOp(numIsaOp), .lastPc(lastPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state
  bit              mRun, mDone;
  int              mReason, mHitG, mHitL;
  longint unsigned mCyc, mUop, mIsa;
  logic [PW-1:0]   mLast;
  logic [PW-1:0]   gPc [GN];
  bit              gEn [GN];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned satInc(input longint unsigned v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  function automatic logic [PW-1:0] lanePc(input int l);
    return commitPc[l*PW +: PW];
  endfunction

  task automatic modelReset();
    mRun = 0; mDone = 0; mReason = 0; mHitG = 0; mHitL = 0;
    mCyc = 0; mUop = 0; mIsa = 0; mLast = '0;
    for (int g = 0; g < GN; g++) begin gPc[g] = '0; gEn[g] = 0; end
  endtask

  // One clock edge of the monitor, from the behavioural rules.
  task automatic modelEdge();
    int best, limit, key;
    if (start) begin
      mRun = 1; mDone = 0; mReason = 0; mHitG = 0; mHitL = 0;
      mCyc = 0; mUop = 0; mIsa = 0; mLast = '0;
    end else if (mRun) begin
      mCyc = satInc(mCyc);
      best = -1;
      for (int l = 0; l < CW; l++)
        for (int g = 0; g < GN; g++)
          if (commitValid[l] && gEn[g] && lanePc(l) == gPc[g]) begin
            key = l * GN + g;
            if (best < 0 || key < best) best = key;
          end
      limit = (best >= 0) ? best / GN : CW - 1;
      for (int l = 0; l <= limit; l++)
        if (commitValid[l]) begin
          mUop = satInc(mUop);
          if (commitFirstUop[l]) mIsa = satInc(mIsa);
          mLast = lanePc(l);
        end
      if (best >= 0) begin
        mRun = 0; mDone = 1; mReason = 1; mHitL = best / GN; mHitG = best % GN;
      end else if (maxCycles != 0 && mCyc == longint'(maxCycles)) begin
        mRun = 0; mDone = 1; mReason = 2;
      end
    end
    if (goalWe && int'(goalIdx) < GN) begin
      gPc[goalIdx] = goalPc;
      gEn[goalIdx] = goalEn;
    end
  endtask

  task automatic compareAll();
    checkVal("running", 64'(running), 64'(mRun));
    checkVal("done", 64'(done), 64'(mDone));
    checkVal("doneReason", 64'(doneReason), 64'(mReason));
    checkVal("hitGoalIdx", 64'(hitGoalIdx), 64'(mHitG));
    checkVal("hitLane", 64'(hitLane), 64'(mHitL));
    checkVal("cycleCount", 64'(cycleCount), mCyc);
    checkVal("numMicroOp", 64'(numMicroOp), mUop);
    checkVal("numIsaOp", 64'(numIsaOp), mIsa);
    checkVal("lastPc", 64'(lastPc), 64'(mLast));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic idleIn();
    start = 0; goalWe = 0; goalIdx = '0; goalPc = '0; goalEn = 0;
    commitValid = '0; commitFirstUop = '0;
  endtask

  task automatic doStart();
    @(negedge clk); idleIn(); start = 1;
    stepCycle();
  endtask

  task automatic writeGoal(input int idx, input logic [PW-1:0] pc, input bit en);
    @(negedge clk); idleIn();
    goalWe = 1; goalIdx = 1'(idx); goalPc = pc; goalEn = en;
    stepCycle();
  endtask

  task automatic commit(input logic [CW-1:0] v, input logic [CW-1:0] f,
                        input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                        input logic [PW-1:0] p2, input logic [PW-1:0] p3);
    @(negedge clk); idleIn();
    commitValid = v; commitFirstUop = f;
    commitPc = {p3, p2, p1, p0};
    stepCycle();
  endtask

  // Asynchronous reset pulse inside the low clock phase.
  task automatic pulseReset();
    #1 rstOut = 0;
    #1 modelReset();
    compareAll();
    #1 rstOut = 1;
  endtask

  int nSteps;

  initial begin
    rstOut = 0; maxCycles = '0; commitPc = '0;
    idleIn();
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    checkVal("reset running", 64'(running), 64'd0);
    checkVal("reset lastPc", 64'(lastPc), 64'd0);
    rstOut = 1;
    commit(4'hF, 4'hF, 32'h10, 32'h14, 32'h18, 32'h1C);  // idle: nothing counted

    // Plain counting
    doStart();
    for (int i = 0; i < 10; i++)
      commit(4'hF, 4'b0101, 32'h4000_0000 + 16*i, 32'h4000_0004 + 16*i,
             32'h4000_0008 + 16*i, 32'h4000_000C + 16*i);
    checkVal("t1 cycleCount", 64'(cycleCount), 64'd10);
    checkVal("t1 numMicroOp", 64'(numMicroOp), 64'd40);
    checkVal("t1 numIsaOp", 64'(numIsaOp), 64'd20);

    // Goal hit on lane 1 truncates counting
    writeGoal(0, 32'h8000_0100, 1);
    commit(4'hF, 4'hF, 32'hFC, 32'h8000_0100, 32'h104, 32'h108);
    checkVal("t2 done", 64'(done), 64'd1);
    checkVal("t2 numMicroOp", 64'(numMicroOp), 64'd42);
    checkVal("t2 hitLane", 64'(hitLane), 64'd1);
    checkVal("t2 lastPc", 64'(lastPc), 64'h8000_0100);
    checkVal("t2 doneReason", 64'(doneReason), 64'd1);

    // Duplicate goals: lowest goal index wins
    doStart();
    checkVal("t3 rearm numMicroOp", 64'(numMicroOp), 64'd0);
    writeGoal(0, 32'h200, 1);
    writeGoal(1, 32'h200, 1);
    commit(4'hF, 4'hF, 32'h10, 32'h20, 32'h200, 32'h30);
    checkVal("t3 hitGoalIdx", 64'(hitGoalIdx), 64'd0);
    checkVal("t3 hitLane", 64'(hitLane), 64'd2);
    checkVal("t3 numMicroOp", 64'(numMicroOp), 64'd3);

    // Timeout
    writeGoal(0, 32'h0, 0);
    writeGoal(1, 32'h0, 0);
    maxCycles = 40'd5;
    doStart();
    nSteps = 0;
    while (nSteps < 20 && !done) begin
      commit(4'hF, 4'b0101, 32'h4000_1000, 32'h4000_1004, 32'h4000_1008, 32'h4000_100C);
      nSteps++;
    end
    checkVal("t4 steps to timeout", 64'(nSteps), 64'd5);
    checkVal("t4 cycleCount", 64'(cycleCount), 64'd5);
    checkVal("t4 doneReason", 64'(doneReason), 64'd2);

    // Goal on the timeout cycle wins
    writeGoal(0, 32'h300, 1);
    doStart();
    for (int i = 0; i < 4; i++)
      commit(4'hF, 4'hF, 32'h4000_2000, 32'h4000_2004, 32'h4000_2008, 32'h4000_200C);
    commit(4'b0001, 4'b0001, 32'h300, 32'h0, 32'h0, 32'h0);
    checkVal("t4b done", 64'(done), 64'd1);
    checkVal("t4b doneReason", 64'(doneReason), 64'd1);
    checkVal("t4b cycleCount", 64'(cycleCount), 64'd5);

    // Non-contiguous lanes; invalid lane 0 carries the goal PC
    maxCycles = '0;
    doStart();
    commit(4'b1010, 4'b1010, 32'h300, 32'h11, 32'h22, 32'h33);
    checkVal("t5 numMicroOp", 64'(numMicroOp), 64'd2);
    checkVal("t5 lastPc", 64'(lastPc), 64'h33);
    checkVal("t5 done", 64'(done), 64'd0);
    commit(4'b0000, 4'b0000, 32'h44, 32'h55, 32'h66, 32'h77);
    checkVal("t5 lastPc hold", 64'(lastPc), 64'h33);

    // Reset mid-RUN, then restart
    for (int i = 0; i < 3; i++)
      commit(4'hF, 4'hF, 32'h4000_3000, 32'h4000_3004, 32'h4000_3008, 32'h4000_300C);
    @(negedge clk); idleIn();
    pulseReset();
    checkVal("t6 running after reset", 64'(running), 64'd0);
    checkVal("t6 cycleCount after reset", 64'(cycleCount), 64'd0);
    stepCycle();
    doStart();
    commit(4'hF, 4'b0011, 32'h4000_4000, 32'h4000_4004, 32'h4000_4008, 32'h4000_400C);
    checkVal("t6 cycleCount restart", 64'(cycleCount), 64'd1);
    checkVal("t6 numMicroOp restart", 64'(numMicroOp), 64'd4);
    checkVal("t6 numIsaOp restart", 64'(numIsaOp), 64'd2);

    // Randomized traffic with a small PC pool so goals hit regularly
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      idleIn();
      start = ($urandom_range(0, 24) == 0) || (done && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 6) == 0) begin
        goalWe  = 1;
        goalIdx = 1'($urandom_range(0, 1));
        goalPc  = 32'h100 + 32'(4 * $urandom_range(0, 15));
        goalEn  = 1'($urandom_range(0, 1));
      end
      commitValid    = 4'($urandom_range(0, 15));
      commitFirstUop = 4'($urandom_range(0, 15));
      for (int l = 0; l < CW; l++)
        commitPc[l*PW +: PW] = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0)
        maxCycles = ($urandom_range(0, 1) == 0) ? '0 : 40'($urandom_range(1, 30));
      if ($urandom_range(0, 199) == 0) pulseReset();
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/commit_goal_monitor.md
# commit_goal_monitor

Synthesizable, parametrised commit-stream monitor that replaces bench-only op counting and PC-goal checking with on-chip logic. It sits beside the commit stage and observes up to COMMIT_WIDTH commit lanes per cycle. It counts committed micro-ops and ISA ops, tracks the last committed PC, and stops on any of GOAL_NUM programmable goal PCs or on a cycle timeout. The stop cause is reported through registered status outputs readable by the debug/IO path.

## Interface
- COMMIT_WIDTH, 4, commit lanes per cycle, lane 0 oldest
- GOAL_NUM, 2, goal-PC table entries (≥1)
- PC_WIDTH, 32, PC width
- CNT_WIDTH, 40, width of cycle and op counters
- clk  in  1  clock
- rstOut  in  1  reset, asynchronous, active-low
- start  in  1  arm/re-arm pulse; clears counters
- maxCycles  in  CNT_WIDTH  timeout limit in RUN cycles; 0 disables timeout; sampled every cycle
- goalWe  in  1  goal-table write strobe
- goalIdx  in  $clog2(GOAL_NUM) (min 1)  entry written
- goalPc  in  PC_WIDTH  goal PC written
- goalEn  in  1  enable bit written with entry
- commitValid  in  COMMIT_WIDTH  lane commits this cycle (may be non-contiguous)
- commitFirstUop  in  COMMIT_WIDTH  lane is first micro-op of its ISA op (mid == 0)
- commitPc  in  COMMIT_WIDTH*PC_WIDTH  lane PCs, lane i at [i*PC_WIDTH +: PC_WIDTH]
- running  out  1  state == RUN
- done  out  1  state == DONE
- doneReason  out  2  0 none, 1 goal, 2 timeout
- hitGoalIdx  out  $clog2(GOAL_NUM)  matched goal entry
- hitLane  out  $clog2(COMMIT_WIDTH)  lane that matched
- cycleCount  out  CNT_WIDTH  RUN cycles elapsed
- numMicroOp  out  CNT_WIDTH  committed micro-ops
- numIsaOp  out  CNT_WIDTH  committed ISA ops
- lastPc  out  PC_WIDTH  PC of youngest counted lane

## Operation
- States: IDLE, RUN, DONE.
- IDLE: counters hold. start moves the state to RUN and clears cycleCount, numMicroOp, numIsaOp, lastPc, doneReason, hitGoalIdx and hitLane.
- RUN:
  - cycleCount increments every cycle.
  - Each valid lane adds 1 to numMicroOp. Each valid lane that also has commitFirstUop set adds 1 to numIsaOp.
  - A lane matches when it is valid and its PC equals an enabled goal entry.
  - Priority among matches: lowest lane first, then lowest goal index.
  - On a match at lane k, only lanes 0..k are counted; younger lanes are ignored. lastPc = PC of lane k, hitLane = k, hitGoalIdx is recorded, doneReason = 1, and the state moves to DONE.
  - With no match, lastPc = PC of the highest valid lane. If no lane is valid, lastPc holds.
  - Timeout: if maxCycles != 0 and the incremented cycleCount equals maxCycles, the state moves to DONE with doneReason = 2. A goal match in the same cycle wins, giving reason 1.
- DONE: all counters and status hold. start re-enters RUN, with the same clears as from IDLE.
- start asserted while in RUN restarts: counters clear and the state stays RUN; commits in that cycle are not counted.
- Goal table:
  - A write updates pc and enable of entry goalIdx.
  - A write is legal in any state and affects matching from the next cycle.
  - A goalIdx ≥ GOAL_NUM is ignored.
- Arithmetic: all counters saturate at 2^CNT_WIDTH−1 and never wrap. A per-cycle increment can be 0..COMMIT_WIDTH, so the adder is widened to avoid overflow before saturation.

## Timing
- All outputs are registered. Commit inputs sampled at edge N are reflected in the counters, lastPc and done after edge N; done is visible in cycle N+1.
- start sampled at edge N gives running = 1 and cleared counters after edge N. The first counted cycle is N+1.
- Reset (rstOut low, asynchronous): state = IDLE, running = 0, done = 0, all counters = 0, doneReason = 0, hitGoalIdx = 0, hitLane = 0, lastPc = 0, all goal entries disabled with PC 0.
- Reset asserted mid-RUN aborts immediately to the reset values. There is no auto-restart after reset release.
- No combinational path runs from inputs to outputs.

## Test plan
- Reset, then start. Drive 10 cycles of commitValid = 4'b1111 with commitFirstUop = 4'b0101 → cycleCount = 10, numMicroOp = 40, numIsaOp = 20.
- Goal0 = 0x8000_0100 enabled. Drive lanes PC {0xFC, 0x8000_0100, 0x104, 0x108}, all valid → done the next cycle; numMicroOp increments by only 2; hitLane = 1; lastPc = 0x8000_0100; doneReason = 1.
- Goal0 = 0x200 and goal1 = 0x200 both enabled, with lane 2 matching → hitGoalIdx = 0, hitLane = 2.
- maxCycles = 5 with no goal → done after RUN cycle 5, cycleCount = 5, doneReason = 2. Then set maxCycles = 5 and place the goal match in cycle 5 → doneReason = 1.
- Non-contiguous commitValid = 4'b1010 → numMicroOp increments by 2 and lastPc = lane 3 PC. commitValid = 0 → lastPc holds.
- Reset pulse mid-RUN after 3 cycles → all outputs 0 and state IDLE. Then start → counting restarts from 0. In DONE, a start pulse re-arms with cleared counters.
